// File: rtl/spi_dep_sync_bank.sv
// spi_dep_sync_bank: reset synchroniser plus N_CH independent async-input synchronisers,
//   each followed by a persistence filter and registered rise/fall pulse generation.
// Latency: signals_o and rise_o/fall_o update SYNC_STAGES+FILTER_CYCLES-1 edges after the first sampling edge.
// Backpressure: none; the bank is free-running and every cycle carries a valid level.
//
// Ports:
//   clk_i           core clock, all flops rising-edge
//   async_nreset_i  asynchronous active-low reset from the system
//   signals_i       N_CH asynchronous channel inputs
//   nreset_o        synchronised reset (async assert, sync deassert); also resets the channel logic
//   signals_o       synchronised and filtered channel levels
//   rise_o          one-cycle pulse when a signals_o bit goes 0->1
//   fall_o          one-cycle pulse when a signals_o bit goes 1->0
module spi_dep_sync_bank #(
  parameter int              N_CH          = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter int              RST_STAGES    = 2,
  parameter int              FILTER_CYCLES = 1,
  parameter logic [N_CH-1:0] RESET_VALUE   = '0
) (
  input  logic            clk_i,
  input  logic            async_nreset_i,
  input  logic [N_CH-1:0] signals_i,
  output logic            nreset_o,
  output logic [N_CH-1:0] signals_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  // A single-cycle filter still needs a 1-bit counter so the datapath stays uniform.
  localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: asserts with async_nreset_i, releases after RST_STAGES
  // clock edges as the constant 1 walks through the chain.
  // ---------------------------------------------------------------------------
  logic [RST_STAGES-1:0] rst_q;

  always_ff @(posedge clk_i or negedge async_nreset_i) begin
    if (!async_nreset_i) begin
      rst_q <= '0;
    end else begin
      rst_q <= {rst_q[RST_STAGES-2:0], 1'b1};
    end
  end

  assign nreset_o = rst_q[RST_STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser chains. Stage 0 samples the raw input; the last
  // stage is the metastability-safe level seen by the filter.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_d;
  logic [N_CH-1:0]                  sync_lvl;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], signals_i};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Persistence filter. The counter tracks how many consecutive cycles the
  // synchronised level has disagreed with the published level; any agreement
  // clears it, so short glitches never reach signals_o. The counter saturates
  // implicitly because it is cleared when it reaches CNT_LAST.
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;
  logic [N_CH-1:0][CNT_W-1:0] cnt_d;
  logic [N_CH-1:0]            lvl_q;
  logic [N_CH-1:0]            lvl_d;
  logic [N_CH-1:0]            rise_q;
  logic [N_CH-1:0]            rise_d;
  logic [N_CH-1:0]            fall_q;
  logic [N_CH-1:0]            fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (sync_lvl[n] == lvl_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        // Disagreement has persisted long enough: publish the new level and
        // flag the direction in the same cycle the level changes.
        cnt_d[n]  = '0;
        lvl_d[n]  = sync_lvl[n];
        rise_d[n] = sync_lvl[n];
        fall_d[n] = ~sync_lvl[n];
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state is held in reset by the synchronised reset, so it leaves
  // reset cleanly on a clock edge. Sync stages and the published level start
  // at RESET_VALUE, which means reset release itself never looks like an edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge nreset_o) begin
    if (!nreset_o) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q  <= '0;
      lvl_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign signals_o = lvl_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: tb/tb_spi_dep_sync_bank.sv
// tb_spi_dep_sync_bank: randomized and directed stimulus against two bank instances
//   (reset level 4'b0000 and 4'b1000) sharing clock, reset and inputs.
// Expected outputs come from a windowed model: a level is published once the
//   synchronised input has disagreed with it for FILTER_CYCLES consecutive active edges.
module tb_spi_dep_sync_bank;

  localparam int         NCH  = 4;
  localparam int         SYNC = 2;
  localparam int         RST  = 3;
  localparam int         FILT = 4;
  localparam logic [3:0] RV0  = 4'b0000;
  localparam logic [3:0] RV1  = 4'b1000;

  logic       clk_i;
  logic       async_nreset_i;
  logic [3:0] signals_i;

  logic       nreset0, nreset1;
  logic [3:0] sig0, rise0, fall0;
  logic [3:0] sig1, rise1, fall1;

  spi_dep_sync_bank #(
    .N_CH(NCH), .SYNC_STAGES(SYNC), .RST_STAGES(RST), .FILTER_CYCLES(FILT), .RESET_VALUE(RV0)
  ) u_dut0 (
    .clk_i(clk_i), .async_nreset_i(async_nreset_i), .signals_i(signals_i),
    .nreset_o(nreset0), .signals_o(sig0), .rise_o(rise0), .fall_o(fall0)
  );

  spi_dep_sync_bank #(
    .N_CH(NCH), .SYNC_STAGES(SYNC), .RST_STAGES(RST), .FILTER_CYCLES(FILT), .RESET_VALUE(RV1)
  ) u_dut1 (
    .clk_i(clk_i), .async_nreset_i(async_nreset_i), .signals_i(signals_i),
    .nreset_o(nreset1), .signals_o(sig1), .rise_o(rise1), .fall_o(fall1)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (evaluated at each rising edge, result queued for monitor)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       nrst;
    logic [3:0] sig0;
    logic [3:0] rise0;
    logic [3:0] fall0;
    logic [3:0] sig1;
    logic [3:0] rise1;
    logic [3:0] fall1;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hist[$];     // input sampled at each active edge since the last reset
  int         rel = 0;     // edges seen since async reset released (saturates at RST)
  logic [3:0] m_out[2];
  logic [3:0] m_rise[2];
  logic [3:0] m_fall[2];

  // Synchronised level after active edge m: the input sampled SYNC-1 edges
  // earlier, or the reset level while the chain is still filling.
  function automatic logic [3:0] s_after(int m, logic [3:0] rv);
    if (m >= SYNC) return hist[m-SYNC];
    return rv;
  endfunction

  always @(posedge clk_i) begin : model
    exp_t       e;
    logic [3:0] rv;
    logic [3:0] sv;
    logic       chg;
    int         k;
    if (!async_nreset_i) begin
      rel = 0;
      hist.delete();
      m_out[0] = RV0;  m_out[1] = RV1;
      m_rise[0] = '0;  m_rise[1] = '0;
      m_fall[0] = '0;  m_fall[1] = '0;
    end else if (rel < RST) begin
      rel++;
      m_rise[0] = '0;  m_rise[1] = '0;
      m_fall[0] = '0;  m_fall[1] = '0;
    end else begin
      k = hist.size() + 1;
      for (int i = 0; i < 2; i++) begin
        rv = (i == 0) ? RV0 : RV1;
        m_rise[i] = '0;
        m_fall[i] = '0;
        for (int n = 0; n < NCH; n++) begin
          chg = 1'b1;
          for (int j = 1; j <= FILT; j++) begin
            sv = s_after(k - j, rv);
            if (sv[n] == m_out[i][n]) chg = 1'b0;
          end
          if (chg) begin
            m_out[i][n] = ~m_out[i][n];
            if (m_out[i][n]) m_rise[i][n] = 1'b1;
            else             m_fall[i][n] = 1'b1;
          end
        end
      end
      hist.push_back(signals_i);
    end
    e.nrst  = (rel >= RST);
    e.sig0  = m_out[0];
    e.rise0 = m_rise[0];
    e.fall0 = m_fall[0];
    e.sig1  = m_out[1];
    e.rise1 = m_rise[1];
    e.fall1 = m_fall[1];
    exp_q.push_back(e);
  end

  // ---------------------------------------------------------------------------
  // Monitor: every falling edge the DUT presents a new output word
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin : monitor
    exp_t ee;
    if (exp_q.size() > 0) begin
      ee = exp_q.pop_front();
      chk("nreset_o[dut0]",  nreset0, ee.nrst);
      chk("nreset_o[dut1]",  nreset1, ee.nrst);
      chk("signals_o[dut0]", sig0,    ee.sig0);
      chk("rise_o[dut0]",    rise0,   ee.rise0);
      chk("fall_o[dut0]",    fall0,   ee.fall0);
      chk("signals_o[dut1]", sig1,    ee.sig1);
      chk("rise_o[dut1]",    rise1,   ee.rise1);
      chk("fall_o[dut1]",    fall1,   ee.fall1);
      chk("rise_and_fall[dut0]", rise0 & fall0, 4'b0000);
      chk("rise_and_fall[dut1]", rise1 & fall1, 4'b0000);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [3:0] v);
    @(negedge clk_i);
    #1 signals_i = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Assert reset between edges and confirm outputs collapse with no clock.
  task automatic assert_reset_now();
    async_nreset_i = 1'b0;
    #1;
    chk("arst nreset_o[dut0]",  nreset0, 1'b0);
    chk("arst nreset_o[dut1]",  nreset1, 1'b0);
    chk("arst signals_o[dut0]", sig0,    RV0);
    chk("arst signals_o[dut1]", sig1,    RV1);
    chk("arst rise_o[dut0]",    rise0,   4'b0000);
    chk("arst fall_o[dut0]",    fall0,   4'b0000);
    chk("arst rise_o[dut1]",    rise1,   4'b0000);
    chk("arst fall_o[dut1]",    fall1,   4'b0000);
  endtask

  task automatic pulse_reset(input int hold_cycles);
    #($urandom_range(0, 2));
    assert_reset_now();
    idle(hold_cycles);
    #($urandom_range(1, 3)) async_nreset_i = 1'b1;
  endtask

  int hold[NCH];

  initial begin
    async_nreset_i = 1'b1;
    signals_i      = 4'b0000;
    #1 async_nreset_i = 1'b0;
    idle(4);
    #2 async_nreset_i = 1'b1;       // released between edges
    idle(8);

    // channel 0 rises and stays high
    drive(4'b0001);
    idle(12);

    // channel 1 glitch of three cycles is swallowed
    drive(4'b0011);
    idle(2);
    drive(4'b0001);
    idle(10);

    // all channels together, then all together back low
    drive(4'b1111);
    idle(12);
    drive(4'b0000);
    idle(12);

    // channel 2 pending count interrupted by reset, restarts after release
    drive(4'b0100);
    idle(3);
    @(negedge clk_i);
    #2 assert_reset_now();
    idle(3);
    #2 async_nreset_i = 1'b1;
    idle(16);

    // channel 3 toggling every two cycles never gets through
    for (int t = 0; t < 16; t++) begin
      drive({~signals_i[3], signals_i[2:0]});
      idle(1);
    end
    drive(4'b0000);
    idle(12);

    // channel 3 held high across a reset: dut1 starts at 1 and never pulses
    drive(4'b1000);
    idle(12);
    @(negedge clk_i);
    #1 pulse_reset(4);
    idle(14);

    // randomized phase with per-channel hold lengths and occasional resets
    for (int n = 0; n < NCH; n++) hold[n] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      #1;
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset($urandom_range(1, 4));
      end else begin
        for (int n = 0; n < NCH; n++) begin
          if (hold[n] == 0) begin
            signals_i[n] = 1'($urandom_range(0, 1));
            hold[n]      = $urandom_range(1, 8);
          end else begin
            hold[n]--;
          end
        end
      end
    end

    idle(4);
    chk("scoreboard drained", exp_q.size() <= 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_dep_sync_bank.md
SPI_DEP_SYNC_BANK -- requirements
Module: spi_dep_sync_bank

Interface
REQ-001 Parameter N_CH, default 4, meaning number of independent input channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, meaning flops per channel synchroniser chain, minimum 2.
REQ-003 Parameter RST_STAGES, default 2, meaning flops in reset synchroniser, minimum 2.
REQ-004 Parameter FILTER_CYCLES, default 1, meaning consecutive mismatching cycles required before the output changes, minimum 1; the value 1 means no filtering.
REQ-005 Parameter RESET_VALUE, default all zeros, N_CH bits, meaning per-channel reset level.
REQ-006 clk_i  input  1  clock; all flops rising-edge.
REQ-007 async_nreset_i  input  1  reset, asynchronous, active-low.
REQ-008 signals_i  input  N_CH  asynchronous channel inputs.
REQ-009 nreset_o  output  1  synchronised reset: asynchronous assert, synchronous deassert.
REQ-010 signals_o  output  N_CH  synchronised, filtered channel levels.
REQ-011 rise_o  output  N_CH  one-cycle pulse per channel when signals_o goes 0->1.
REQ-012 fall_o  output  N_CH  one-cycle pulse per channel when signals_o goes 1->0.

Function
REQ-013 Reset synchroniser SHALL be a RST_STAGES-deep shift chain that shifts in constant 1; nreset_o is the last stage.
REQ-014 nreset_o SHALL rise on the RST_STAGES-th rising clk_i edge after async_nreset_i deasserts.
REQ-015 All channel logic SHALL be asynchronously reset by the internal nreset_o and held in reset while nreset_o is low.
REQ-016 Each channel SHALL pass signals_i[n] through SYNC_STAGES flops; s[n] is the last stage.
REQ-017 Each channel SHALL own a counter cnt[n], width max(1,clog2(FILTER_CYCLES)).
REQ-018 When s[n]==signals_o[n], cnt[n] SHALL be cleared to 0.
REQ-019 When s[n]!=signals_o[n] and cnt[n]==FILTER_CYCLES-1, signals_o[n] SHALL load s[n] and cnt[n] SHALL be cleared.
REQ-020 When s[n]!=signals_o[n] and cnt[n]<FILTER_CYCLES-1, cnt[n] SHALL increment by 1; the counter never wraps.
REQ-021 For an input stable from sampling edge E, signals_o[n] SHALL change at edge E+SYNC_STAGES+FILTER_CYCLES-1, i.e. visible SYNC_STAGES+FILTER_CYCLES edges after the first sampling edge, counting that edge.
REQ-022 A mismatch lasting fewer than FILTER_CYCLES consecutive cycles at s[n] SHALL NOT change signals_o[n] and SHALL NOT pulse.
REQ-023 rise_o[n] and fall_o[n] SHALL be registered and asserted on the same edge signals_o[n] changes, for exactly one cycle.
REQ-024 rise_o[n] and fall_o[n] SHALL never be high simultaneously.
REQ-025 Channels SHALL be fully independent; simultaneous changes on any subset SHALL update in the same cycle.
REQ-026 Reset release SHALL NOT itself generate a pulse; an input differing from RESET_VALUE is filtered normally afterwards.

Reset
REQ-027 Asserting async_nreset_i SHALL immediately, without clock, drive nreset_o=0, signals_o=RESET_VALUE, rise_o=0, fall_o=0.
REQ-028 The same assertion SHALL set all sync stages to RESET_VALUE and cnt=0.
REQ-029 Reset asserted mid-filter SHALL discard pending count; after release, filtering restarts from 0.

Verification (N_CH=4, SYNC_STAGES=2, RST_STAGES=3, FILTER_CYCLES=4, RESET_VALUE=4'b0000 unless stated)
REQ-030 Release async_nreset_i between edges -> nreset_o high after 3rd rising edge; signals_o=0, no pulses.
REQ-031 signals_i[0] 0->1 held -> signals_o[0]=1 visible 6 edges after first sampling edge; rise_o[0] high exactly 1 cycle.
REQ-032 signals_i[1] high for 3 cycles then low -> signals_o[1] stays 0, no rise_o/fall_o.
REQ-033 signals_i=4'b1111 in one cycle, later 4'b0000 -> all four signals_o bits change same cycle; rise_o=4'b1111 then fall_o=4'b1111, each 1 cycle.
REQ-034 Assert async_nreset_i when cnt[2]==2 -> all outputs 0 with no clock; after release pending input needs full 4 cycles again.
REQ-035 signals_i[3] toggling every 2 cycles -> signals_o[3] never changes; RESET_VALUE=4'b1000 -> signals_o[3]=1 in reset, no pulse on release.
